fifo_rd_sched: RTL and testbench
================================

FIFO_RD_SCHED -- requirements
Module: fifo_rd_sched

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the total FIFO word width including the tag field in the top bits.
REQ-002 The block SHALL have parameter FLUX, default 2, meaning the number of flows (requesters) sharing one tagged FIFO; legal range is 2 to 16.
REQ-003 The block SHALL have derived parameter TAG_WIDTH = $clog2(FLUX), meaning the tag field width, located at datain/dataout[WIDTH-1:WIDTH-TAG_WIDTH].
REQ-004 The block SHALL have port ck, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port req, input, FLUX bits: per-flow read request, level-sensitive.
REQ-007 The block SHALL have port fifo_empty, input, FLUX bits: per-flow empty flags from the shared FIFO.
REQ-008 The block SHALL have port fifo_dataout, input, WIDTH bits: FIFO read data.
REQ-009 The block SHALL have port fifo_rd, output, FLUX bits: one-hot read strobe to the FIFO.
REQ-010 The block SHALL have port out_data, output, WIDTH bits: captured word.
REQ-011 The block SHALL have port out_flux, output, TAG_WIDTH bits: index of the flow that owns out_data.
REQ-012 The block SHALL have port out_valid, output, 1 bit: out_data/out_flux valid.
REQ-013 The block SHALL have port out_ready, input, 1 bit: consumer accepts the word.
REQ-014 The block SHALL have port tag_err, output, 1 bit: one-cycle pulse on a tag mismatch.
REQ-015 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-016 The block SHALL implement FSM states IDLE, ISSUE, CAPT and HOLD, encoded in a 2-bit state register.
REQ-017 In IDLE, eligible[i] = req[i] & ~fifo_empty[i]; if any flow is eligible, the block SHALL register gnt as the first eligible index searching upward from rr_ptr, with modulo-FLUX wrap, and go to ISSUE.
REQ-018 In ISSUE, fifo_rd SHALL equal onehot(gnt) for exactly one cycle, after which the state SHALL go to CAPT; fifo_rd SHALL be all-zero in every other state.
REQ-019 In ISSUE, if fifo_empty[gnt]=1, the block SHALL suppress fifo_rd, return to IDLE and leave rr_ptr unchanged.
REQ-020 In CAPT, the block SHALL register out_data <= fifo_dataout and out_flux <= gnt, then go to HOLD.
REQ-021 In CAPT, if fifo_dataout tag != gnt, tag_err SHALL pulse in the following cycle; the data SHALL still be delivered.
REQ-022 In HOLD, out_valid SHALL be 1; out_data and out_flux SHALL be stable until out_ready=1.
REQ-023 On HOLD with out_ready=1, the block SHALL go to IDLE and set rr_ptr <= (gnt+1) mod FLUX, with explicit wrap for non-power-of-2 FLUX.
REQ-024 Latency: eligible at cycle 0 -> fifo_rd at cycle 1 -> out_valid from cycle 3; minimum 4 cycles per word with out_ready held high.
REQ-025 A req deassertion after the grant SHALL NOT abort the transaction.
REQ-026 The block SHALL have no more than one read outstanding.
REQ-027 If all flows are empty or no flow requests, the block SHALL remain in IDLE with all outputs quiet.
REQ-028 A flow requesting continuously SHALL be granted at least once every FLUX transactions.
REQ-029 out_ready while out_valid=0 SHALL be ignored.

Reset
REQ-030 On rst=0, the block SHALL asynchronously force: state=IDLE, fifo_rd=0, out_valid=0, out_data=0, out_flux=0, tag_err=0, busy=0, gnt=0, rr_ptr=0.
REQ-031 Reset asserted mid-ISSUE SHALL drop fifo_rd within the same cycle; no capture SHALL occur after release.
REQ-032 After rst release, the first grant search SHALL start from flow 0.

Verification
REQ-033 FLUX=2: req=2'b11, fifo_empty=2'b00, out_ready=1 -> fifo_rd sequence 01, 10, 01, with a 4-cycle spacing.
REQ-034 FLUX=4: req=4'b1000 only, fifo_empty=0, fifo_dataout tag=3 -> fifo_rd=4'b1000 at cycle 1, out_valid at cycle 3, out_flux=3, tag_err=0.
REQ-035 Hold out_ready=0 for 5 cycles in HOLD -> out_valid stays 1, out_data stays constant, fifo_rd stays 0; out_ready=1 -> IDLE next cycle.
REQ-036 fifo_dataout tag=1 while gnt=0 -> tag_err=1 for exactly one cycle, out_data still presented.
REQ-037 Assert rst=0 during ISSUE -> fifo_rd=0 immediately; after release with req=2'b10 -> first grant is flow 1, with rr_ptr restarting from 0.
REQ-038 FLUX=3: all flows requesting and non-empty for 6 transactions -> grants 0,1,2,0,1,2 (wrap from 2 to 0).

Source files
------------

// File: rtl/fifo_rd_sched.sv
// Round-robin read scheduler for a shared, tagged FIFO: grants one flow at a time,
// issues a single read strobe, captures the word and holds it until the consumer accepts.
module fifo_rd_sched #(
  parameter  int WIDTH     = 8,
  parameter  int FLUX      = 2,
  localparam int TAG_WIDTH = $clog2(FLUX)
) (
  input  logic                 ck,
  input  logic                 rst,
  input  logic [FLUX-1:0]      req,
  input  logic [FLUX-1:0]      fifo_empty,
  input  logic [WIDTH-1:0]     fifo_dataout,
  output logic [FLUX-1:0]      fifo_rd,
  output logic [WIDTH-1:0]     out_data,
  output logic [TAG_WIDTH-1:0] out_flux,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 tag_err,
  output logic                 busy
);

  localparam int IW = TAG_WIDTH + 1;
  typedef logic [IW-1:0]        idx_t;
  typedef logic [TAG_WIDTH-1:0] tag_t;
  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, HOLD} state_t;

  state_t          state_q, state_d;
  tag_t            gnt, rr_ptr, srch_gnt;
  logic [FLUX-1:0] elig;
  idx_t            idx;
  logic            any_elig, ld_gnt, capt, adv_rr;

  assign elig = req & ~fifo_empty;

  // Scan downward so the eligible flow closest to rr_ptr is the last one written.
  always_comb begin
    srch_gnt = '0;
    any_elig = 1'b0;
    idx      = '0;
    for (int k = FLUX-1; k >= 0; k--) begin
      idx = idx_t'(rr_ptr) + idx_t'(k);
      if (idx >= idx_t'(FLUX)) idx = idx - idx_t'(FLUX);
      if (elig[idx[TAG_WIDTH-1:0]]) begin
        srch_gnt = idx[TAG_WIDTH-1:0];
        any_elig = 1'b1;
      end
    end
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // fifo_rd is decoded from the state so an async reset removes it in the same cycle.
  always_comb begin
    state_d = state_q;
    fifo_rd = '0;
    ld_gnt  = 1'b0;
    capt    = 1'b0;
    adv_rr  = 1'b0;
    case (state_q)
      IDLE:  if (any_elig) begin
               state_d = ISSUE;
               ld_gnt  = 1'b1;
             end
      ISSUE: if (fifo_empty[gnt]) state_d = IDLE;
             else begin
               state_d      = CAPT;
               fifo_rd[gnt] = 1'b1;
             end
      CAPT:  begin
               state_d = HOLD;
               capt    = 1'b1;
             end
      HOLD:  if (out_ready) begin
               state_d = IDLE;
               adv_rr  = 1'b1;
             end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      gnt      <= '0;
      rr_ptr   <= '0;
      out_data <= '0;
      out_flux <= '0;
      tag_err  <= 1'b0;
    end else begin
      tag_err <= capt && (fifo_dataout[WIDTH-1 -: TAG_WIDTH] != gnt);
      if (ld_gnt) gnt <= srch_gnt;
      if (capt) begin
        out_data <= fifo_dataout;
        out_flux <= gnt;
      end
      if (adv_rr) rr_ptr <= (gnt == tag_t'(FLUX-1)) ? '0 : gnt + 1'b1;
    end
  end

  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_rd_sched.sv
// Directed bench for fifo_rd_sched: a FLUX=2 vector table plus hand sequences for
// reset-in-ISSUE, FLUX=4 latency and FLUX=3 round-robin wrap.
module tb_fifo_rd_sched;

  logic ck = 1'b0;
  logic rst;
  always #5 ck = ~ck;

  // FLUX=2 instance
  logic [1:0] req2, emp2, rd2;
  logic [7:0] din2, dout2;
  logic       flux2, vld2, rdy2, terr2, busy2;
  // FLUX=3 instance
  logic [2:0] req3, emp3, rd3;
  logic [7:0] din3, dout3;
  logic [1:0] flux3;
  logic       vld3, rdy3, terr3, busy3;
  // FLUX=4 instance
  logic [3:0] req4, emp4, rd4;
  logic [7:0] din4, dout4;
  logic [1:0] flux4;
  logic       vld4, rdy4, terr4, busy4;

  fifo_rd_sched #(.WIDTH(8), .FLUX(2)) dut2 (
    .ck(ck), .rst(rst), .req(req2), .fifo_empty(emp2), .fifo_dataout(din2),
    .fifo_rd(rd2), .out_data(dout2), .out_flux(flux2), .out_valid(vld2),
    .out_ready(rdy2), .tag_err(terr2), .busy(busy2));

  fifo_rd_sched #(.WIDTH(8), .FLUX(3)) dut3 (
    .ck(ck), .rst(rst), .req(req3), .fifo_empty(emp3), .fifo_dataout(din3),
    .fifo_rd(rd3), .out_data(dout3), .out_flux(flux3), .out_valid(vld3),
    .out_ready(rdy3), .tag_err(terr3), .busy(busy3));

  fifo_rd_sched #(.WIDTH(8), .FLUX(4)) dut4 (
    .ck(ck), .rst(rst), .req(req4), .fifo_empty(emp4), .fifo_dataout(din4),
    .fifo_rd(rd4), .out_data(dout4), .out_flux(flux4), .out_valid(vld4),
    .out_ready(rdy4), .tag_err(terr4), .busy(busy4));

  typedef struct {
    logic [1:0] req, emp;
    logic [7:0] din;
    logic       rdy;
    logic [1:0] rd;
    logic       vld;
    logic [7:0] dout;
    logic       flux, terr, busy;
  } vec_t;

  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  initial begin
    logic got;
    logic [13:0] act, exp;

    // req,emp,din,rdy | rd,vld,dout,flux,terr,busy
    tbl.push_back('{2'b11, 2'b00, 8'h00, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}); // IDLE -> gnt0
    tbl.push_back('{2'b11, 2'b00, 8'h00, 1'b1, 2'b01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1}); // ISSUE
    tbl.push_back('{2'b11, 2'b00, 8'h15, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1}); // CAPT
    tbl.push_back('{2'b11, 2'b00, 8'h00, 1'b1, 2'b00, 1'b1, 8'h15, 1'b0, 1'b0, 1'b1}); // HOLD
    tbl.push_back('{2'b11, 2'b00, 8'h00, 1'b1, 2'b00, 1'b0, 8'h15, 1'b0, 1'b0, 1'b0}); // IDLE -> gnt1
    tbl.push_back('{2'b11, 2'b00, 8'h00, 1'b1, 2'b10, 1'b0, 8'h15, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{2'b11, 2'b00, 8'h9A, 1'b1, 2'b00, 1'b0, 8'h15, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{2'b11, 2'b00, 8'h00, 1'b1, 2'b00, 1'b1, 8'h9A, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{2'b11, 2'b00, 8'h00, 1'b1, 2'b00, 1'b0, 8'h9A, 1'b1, 1'b0, 1'b0}); // wrap -> gnt0
    tbl.push_back('{2'b11, 2'b00, 8'h00, 1'b1, 2'b01, 1'b0, 8'h9A, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{2'b11, 2'b00, 8'h83, 1'b1, 2'b00, 1'b0, 8'h9A, 1'b1, 1'b0, 1'b1}); // tag 1 vs gnt 0
    tbl.push_back('{2'b11, 2'b00, 8'hFF, 1'b0, 2'b00, 1'b1, 8'h83, 1'b0, 1'b1, 1'b1}); // tag_err pulse
    for (int i = 0; i < 4; i++)
      tbl.push_back('{2'b11, 2'b00, 8'hFF, 1'b0, 2'b00, 1'b1, 8'h83, 1'b0, 1'b0, 1'b1}); // stall
    tbl.push_back('{2'b00, 2'b00, 8'hFF, 1'b1, 2'b00, 1'b1, 8'h83, 1'b0, 1'b0, 1'b1}); // accept
    tbl.push_back('{2'b00, 2'b00, 8'h00, 1'b1, 2'b00, 1'b0, 8'h83, 1'b0, 1'b0, 1'b0}); // no req
    tbl.push_back('{2'b11, 2'b11, 8'h00, 1'b1, 2'b00, 1'b0, 8'h83, 1'b0, 1'b0, 1'b0}); // all empty
    tbl.push_back('{2'b01, 2'b00, 8'h00, 1'b1, 2'b00, 1'b0, 8'h83, 1'b0, 1'b0, 1'b0}); // rr1 -> gnt0
    tbl.push_back('{2'b01, 2'b01, 8'h00, 1'b1, 2'b00, 1'b0, 8'h83, 1'b0, 1'b0, 1'b1}); // empty in ISSUE
    tbl.push_back('{2'b11, 2'b00, 8'h00, 1'b1, 2'b00, 1'b0, 8'h83, 1'b0, 1'b0, 1'b0}); // rr still 1
    tbl.push_back('{2'b00, 2'b00, 8'h00, 1'b1, 2'b10, 1'b0, 8'h83, 1'b0, 1'b0, 1'b1}); // req drop
    tbl.push_back('{2'b00, 2'b00, 8'hC4, 1'b1, 2'b00, 1'b0, 8'h83, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{2'b00, 2'b00, 8'h00, 1'b1, 2'b00, 1'b1, 8'hC4, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{2'b00, 2'b00, 8'h00, 1'b1, 2'b00, 1'b0, 8'hC4, 1'b1, 1'b0, 1'b0});

    rst = 1'b0;
    req2 = 2'b11; emp2 = '0; din2 = 8'hA5; rdy2 = 1'b1;
    req3 = 3'b111; emp3 = '0; din3 = '0; rdy3 = 1'b1;
    req4 = 4'b1111; emp4 = '0; din4 = '0; rdy4 = 1'b1;
    repeat (2) @(negedge ck);
    #1;
    chk("rst_rd2",   32'(rd2),   32'h0);
    chk("rst_vld2",  32'(vld2),  32'h0);
    chk("rst_dout2", 32'(dout2), 32'h0);
    chk("rst_flux2", 32'(flux2), 32'h0);
    chk("rst_terr2", 32'(terr2), 32'h0);
    chk("rst_busy2", 32'(busy2), 32'h0);
    chk("rst_busy3", 32'(busy3), 32'h0);
    chk("rst_busy4", 32'(busy4), 32'h0);

    @(negedge ck);
    rst = 1'b1; req2 = '0; req3 = '0; req4 = '0;

    foreach (tbl[i]) begin
      @(negedge ck);
      req2 = tbl[i].req; emp2 = tbl[i].emp; din2 = tbl[i].din; rdy2 = tbl[i].rdy;
      #1;
      act = {rd2, vld2, dout2, flux2, terr2, busy2};
      exp = {tbl[i].rd, tbl[i].vld, tbl[i].dout, tbl[i].flux, tbl[i].terr, tbl[i].busy};
      chk($sformatf("vec%0d {rd,vld,data,flux,terr,busy}", i), 32'(act), 32'(exp));
    end

    // Move rr_ptr to 1, then reset while flow 1 is being issued.
    @(negedge ck); req2 = 2'b01; emp2 = '0; din2 = 8'h11; rdy2 = 1'b1;
    @(negedge ck); #1 chk("pre_rst_rd", 32'(rd2), 32'h1);
    @(negedge ck);
    @(negedge ck); #1 chk("pre_rst_vld", 32'(vld2), 32'h1);
    req2 = 2'b11;
    @(negedge ck);
    @(negedge ck); #1 chk("rr_adv_rd", 32'(rd2), 32'h2);
    #1 rst = 1'b0;
    #1;
    chk("rst_issue_rd",   32'(rd2),   32'h0);
    chk("rst_issue_busy", 32'(busy2), 32'h0);
    chk("rst_issue_dout", 32'(dout2), 32'h0);
    @(negedge ck); rst = 1'b1;
    @(negedge ck); #1 chk("rst_rr_zero_rd", 32'(rd2), 32'h1);
    #1 rst = 1'b0;
    #1 chk("rst_issue2_rd", 32'(rd2), 32'h0);
    @(negedge ck); rst = 1'b1; req2 = 2'b10;
    @(negedge ck); #1 chk("rst_first_gnt1", 32'(rd2), 32'h2);
    #1 rst = 1'b0;
    @(negedge ck); rst = 1'b1; req2 = 2'b00;
    for (int c = 0; c < 3; c++) begin
      @(negedge ck); #1;
      chk("no_capt_vld",  32'(vld2),  32'h0);
      chk("no_capt_dout", 32'(dout2), 32'h0);
    end

    // FLUX=4: single requester, tag 3, cycle-exact latency.
    @(negedge ck); req4 = 4'b1000; emp4 = '0; din4 = 8'hC7; rdy4 = 1'b1;
    #1 chk("f4_c0_rd", 32'(rd4), 32'h0);
    @(negedge ck); #1 chk("f4_c1_rd", 32'(rd4), 32'h8);
    req4 = '0;
    @(negedge ck); #1 chk("f4_c2_vld", 32'(vld4), 32'h0);
    @(negedge ck); #1;
    chk("f4_c3_vld",  32'(vld4),  32'h1);
    chk("f4_c3_flux", 32'(flux4), 32'h3);
    chk("f4_c3_data", 32'(dout4), 32'hC7);
    chk("f4_c3_terr", 32'(terr4), 32'h0);
    @(negedge ck); #1 chk("f4_c4_busy", 32'(busy4), 32'h0);

    // FLUX=3: everyone requesting; grants must cycle 0,1,2,0,1,2.
    @(negedge ck); req3 = 3'b111; emp3 = '0; rdy3 = 1'b1; din3 = {2'd0, 6'h00};
    for (int t = 0; t < 6; t++) begin
      got = 1'b0;
      for (int c = 0; c < 8; c++) begin
        @(negedge ck); #1;
        if (vld3) begin
          got = 1'b1;
          break;
        end
      end
      chk($sformatf("f3_t%0d_vld", t),  32'(got),   32'h1);
      chk($sformatf("f3_t%0d_flux", t), 32'(flux3), 32'(t % 3));
      chk($sformatf("f3_t%0d_data", t), 32'(dout3), 32'({2'(t % 3), 6'(t)}));
      chk($sformatf("f3_t%0d_terr", t), 32'(terr3), 32'h0);
      din3 = {2'((t + 1) % 3), 6'(t + 1)};
    end
    req3 = '0;
    repeat (2) @(negedge ck);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
